// File: rtl/data_chan_pkg.sv
// Shared types and widths for the data channel elastic buffer.
package data_chan_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] chan_data_t;

endpackage : data_chan_pkg

// File: rtl/data_chan_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port.
module data_chan_fifo_mem #(
    parameter int unsigned DATA_W = data_chan_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; out_valid qualifies the read data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : data_chan_fifo_mem

// File: rtl/data_chan_fifo.sv
// First-word-fall-through elastic buffer with valid/ready handshake and
// a saturating count of cycles where the producer was refused.
module data_chan_fifo #(
    parameter int unsigned DATA_W  = data_chan_pkg::DATA_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned STALL_W = 16,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned PW     = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PW-1:0]      count,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full && !flush && !rst;
    assign out_valid = !empty && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + PW'(1);
            end else if (pop && !push) begin
                count <= count - PW'(1);
            end
        end
    end

    // Stall accounting survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    data_chan_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

endmodule : data_chan_fifo

// File: tb/tb_data_chan_fifo.sv
// Self-checking bench for data_chan_fifo: vector table plus queue scoreboard.
module tb_data_chan_fifo;
    import data_chan_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    chan_data_t    in_data;
    logic          in_valid;
    logic          in_ready;
    chan_data_t    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic [15:0]   stall_cnt;

    logic          rst2;
    logic          flush2;
    chan_data_t    in_data2;
    logic          in_valid2;
    logic          in_ready2;
    chan_data_t    out_data2;
    logic          out_valid2;
    logic          out_ready2;
    logic [CW-1:0] count2;
    logic [1:0]    stall2;

    always #5 clk = ~clk;

    data_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .stall_cnt(stall_cnt)
    );

    data_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .flush(flush2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .count(count2), .stall_cnt(stall2)
    );

    typedef struct {
        logic       iv;
        chan_data_t d;
        logic       ordy;
        logic       fl;
        logic       r;
        logic       ir;
        logic       ov;
        int         cnt;
        int         st;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    chan_data_t sb[$];
    int         m_stall;
    vec_t       tab[20];

    function automatic vec_t mk(input logic iv, input chan_data_t d, input logic ordy,
                                input logic fl, input logic r, input logic ir,
                                input logic ov, input int cnt, input int st);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.r = r;
        v.ir = ir; v.ov = ov; v.cnt = cnt; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, compare against table or model, then advance the model.
    task automatic cyc(input vec_t v, input bit use_tab);
        logic m_ir, m_ov, e_ir, e_ov;
        int   e_cnt, e_st;
        in_valid = v.iv; in_data = v.d; out_ready = v.ordy; flush = v.fl; rst = v.r;
        #1;
        m_ir  = (sb.size() < DEPTH) && !v.fl && !v.r;
        m_ov  = (sb.size() > 0) && !v.fl;
        e_ir  = use_tab ? v.ir  : m_ir;
        e_ov  = use_tab ? v.ov  : m_ov;
        e_cnt = use_tab ? v.cnt : sb.size();
        e_st  = use_tab ? v.st  : m_stall;
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("count", 32'(count), 32'(e_cnt));
        chk("stall_cnt", 32'(stall_cnt), 32'(e_st));
        if (e_ov && sb.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(sb[0]));
        end
        if (v.r) begin
            sb.delete();
            m_stall = 0;
        end else begin
            if (v.iv && !m_ir && m_stall < 65535) m_stall++;
            if (v.fl) begin
                sb.delete();
            end else begin
                if (m_ov && v.ordy) void'(sb.pop_front());
                if (v.iv && m_ir) sb.push_back(v.d);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        sb.delete();
        m_stall = 0;
        tick();
        rst2 = 1'b0;

        //              iv    data      ordy  fl    r     ir    ov   cnt st
        tab[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        tab[1]  = mk(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tab[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
        tab[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
        tab[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tab[5]  = mk(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tab[6]  = mk(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
        tab[7]  = mk(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0);
        tab[8]  = mk(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0);
        tab[9]  = mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
        tab[10] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1);
        tab[11] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 2);
        tab[12] = mk(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 3);
        tab[13] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 4);
        tab[14] = mk(1'b1, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 4);
        tab[15] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
        tab[16] = mk(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
        tab[17] = mk(1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 5);
        tab[18] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 5);
        tab[19] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            cyc(tab[i], 1'b1);
        end

        // Streaming at occupancy 1 walks both pointers past the wrap point.
        cyc(mk(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(mk(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);
        end
        cyc(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);
        cyc(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);

        // Flush coinciding with reset behaves as reset.
        cyc(mk(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);
        cyc(mk(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);
        cyc(mk(1'b1, 16'h0202, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0), 1'b0);
        cyc(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0), 1'b0);

        // Narrow stall counter saturates at 3.
        in_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data2 = 16'h0010 + 16'(i);
            tick();
        end
        chk("sat_count_full", 32'(count2), 32'd4);
        chk("sat_in_ready", 32'(in_ready2), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_stall_3", 32'(stall2), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_stall_hold", 32'(stall2), 32'd3);
        chk("sat_head", 32'(out_data2), 32'h0010);
        in_valid2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_chan_fifo
